// File: rtl/rotator_pattern_sequencer_pkg.sv
// Shared encodings for the rotator pattern sequencer: FSM states, direction
// constants and datapath widths.
package rotator_pattern_sequencer_pkg;

  localparam int unsigned PAT_W    = 8;
  localparam int unsigned AMT_W    = 3;
  localparam int unsigned SHIFTS_W = 4;

  localparam logic [PAT_W-1:0] RESET_PATTERN = 8'h01;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/rotator_pattern_sequencer_if.sv
// Link between the sequencer and the 8-bit combinational rotator.
interface rotator_pattern_sequencer_if;
  import rotator_pattern_sequencer_pkg::*;

  logic [PAT_W-1:0]    sh_a;
  logic                sh_rsh;
  logic [SHIFTS_W-1:0] sh_shifts;
  logic [PAT_W-1:0]    sh_y;

  modport master (output sh_a, output sh_rsh, output sh_shifts, input sh_y);
  modport slave  (input sh_a, input sh_rsh, input sh_shifts, output sh_y);
endinterface

// File: rtl/rotator_pattern_sequencer_tick_prescaler.sv
// Modulo-TICK_DIV counter with enable and synchronous clear; tick_c marks the
// last enabled count of each period.
module rotator_pattern_sequencer_tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rotator_pattern_sequencer.sv
// Stepping rotate sequencer: drives an external rotator and commits its result
// to the pattern register on every prescaled tick, with pause/stop and bounce.
module rotator_pattern_sequencer
  import rotator_pattern_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned STEP_LIMIT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [PAT_W-1:0]     load_pattern,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 dir_in,
  input  logic [AMT_W-1:0]     step_amt,
  input  logic                 bounce,
  rotator_pattern_sequencer_if.master sh,
  output logic [PAT_W-1:0]     pattern,
  output logic                 running,
  output logic                 step_done
);

  localparam int unsigned CNT_W = $clog2(STEP_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_LIMIT - 1);

  state_t             state, state_nxt;
  logic               launch_c;
  logic               tick_c;
  logic               step_c;
  logic               dir_reg;
  logic               bounce_reg;
  logic [AMT_W-1:0]   amt_reg;
  logic [CNT_W-1:0]   step_cnt;

  assign sh.sh_a      = pattern;
  assign sh.sh_rsh    = dir_reg;
  assign sh.sh_shifts = {1'b0, amt_reg};

  // The cycle that samples stop in RUN still counts; the count holds from PAUSE on.
  rotator_pattern_sequencer_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (state == RUN),
    .clr    (load || launch_c),
    .tick_c (tick_c)
  );

  assign step_c = tick_c && !load;

  // Next-state logic; stop always wins over start.
  always_comb begin
    state_nxt = state;
    launch_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          launch_c  = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pattern, latched controls and bounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern    <= RESET_PATTERN;
      dir_reg    <= DIR_RIGHT;
      amt_reg    <= '0;
      bounce_reg <= 1'b0;
      step_cnt   <= '0;
      running    <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      running   <= (state_nxt == RUN);
      step_done <= step_c;
      if (launch_c) begin
        dir_reg    <= dir_in;
        amt_reg    <= step_amt;
        bounce_reg <= bounce;
        step_cnt   <= '0;
      end
      if (load) begin
        pattern  <= load_pattern;
        step_cnt <= '0;
      end else if (step_c) begin
        pattern <= sh.sh_y;
        if (bounce_reg) begin
          if (step_cnt == CNT_LAST) begin
            step_cnt <= '0;
            dir_reg  <= ~dir_reg;
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rotator_pattern_sequencer.sv
// Scoreboard bench for rotator_pattern_sequencer with a behavioural rotator
// closing the sh_* loop.
module tb_rotator_pattern_sequencer;
  import rotator_pattern_sequencer_pkg::*;

  typedef struct {
    logic [7:0] pat;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_pattern;
  logic       start;
  logic       stop;
  logic       dir_in;
  logic [2:0] step_amt;
  logic       bounce;
  logic [7:0] pattern;
  logic       running;
  logic       step_done;

  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  rotator_pattern_sequencer_if rif();

  function automatic logic [7:0] rot(input logic [7:0] a, input logic left, input logic [3:0] n);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < int'(n[2:0]); i++)
      r = (left == DIR_LEFT) ? {r[6:0], r[7]} : {r[0], r[7:1]};
    return r;
  endfunction

  assign rif.sh_y = rot(rif.sh_a, rif.sh_rsh, rif.sh_shifts);

  rotator_pattern_sequencer #(.TICK_DIV(4), .STEP_LIMIT(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_pattern (load_pattern),
    .start        (start),
    .stop         (stop),
    .dir_in       (dir_in),
    .step_amt     (step_amt),
    .bounce       (bounce),
    .sh           (rif.master),
    .pattern      (pattern),
    .running      (running),
    .step_done    (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every step_done must match the oldest expected step.
  always @(negedge clk) begin
    if (!reset && step_done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected: pattern %02h at cycle %0d, none required", pattern, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (pattern !== e.pat || cyc != e.cyc) begin
          errors++;
          $display("FAIL step: got %02h at cycle %0d, required %02h at cycle %0d",
                   pattern, cyc, e.pat, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] pat, input int c);
    exp_t e;
    e.pat = pat;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Load a pattern, then start with the given controls; c is the cycle before the start edge.
  task automatic go(input logic [7:0] pat, input logic d, input logic [2:0] amt,
                    input logic bnc, output int c);
    @(negedge clk);
    load = 1'b1; load_pattern = pat;
    @(negedge clk);
    load = 1'b0; dir_in = d; step_amt = amt; bounce = bnc; start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic halt(input string name);
    stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stop = 1'b0;
    chk({name, "_running"}, 32'(running), 32'd0);
  endtask

  initial begin
    int c;
    cyc = 0; checks = 0; errors = 0;
    reset = 1'b1; load = 1'b0; load_pattern = 8'h00; start = 1'b0; stop = 1'b0;
    dir_in = 1'b0; step_amt = 3'd0; bounce = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pattern", 32'(pattern), 32'h01);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_sh_a", 32'(rif.sh_a), 32'h01);
    chk("rst_sh_rsh", 32'(rif.sh_rsh), 32'd0);
    chk("rst_sh_shifts", 32'(rif.sh_shifts), 32'd0);

    // Left by 1 from 81.
    go(8'h81, 1'b1, 3'd1, 1'b0, c);
    push(8'h03, c + 5); push(8'h06, c + 9);
    chk("t2_running", 32'(running), 32'd1);
    chk("t2_sh_shifts", 32'(rif.sh_shifts), 32'h1);
    chk("t2_sh_rsh", 32'(rif.sh_rsh), 32'd1);
    wait_to(c + 9);
    halt("t2");
    chk("t2_pattern_idle", 32'(pattern), 32'h06);

    // Right by 3 from 01.
    go(8'h01, 1'b0, 3'd3, 1'b0, c);
    push(8'h20, c + 5); push(8'h04, c + 9); push(8'h80, c + 13); push(8'h10, c + 17);
    wait_to(c + 17);
    halt("t3");

    // Zero rotate amount still commits a step.
    go(8'h5A, 1'b1, 3'd0, 1'b0, c);
    push(8'h5A, c + 5);
    wait_to(c + 5);
    halt("amt0");

    // Bounce: 7 left, 7 right, then left again.
    go(8'h01, 1'b1, 3'd1, 1'b1, c);
    begin
      logic [7:0] seq [15];
      seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      for (int k = 0; k < 15; k++) push(seq[k], c + 5 + 4 * k);
    end
    wait_to(c + 61);
    halt("t4");
    bounce = 1'b0;

    // Pause with prescaler at 2, hold 10 cycles, resume.
    go(8'h01, 1'b1, 3'd1, 1'b0, c);
    push(8'h02, c + 5);
    wait_to(c + 7);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_paused_running", 32'(running), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_hold_pattern", 32'(pattern), 32'h02);
    end
    start = 1'b1;
    push(8'h04, c + 20); push(8'h08, c + 24);
    @(negedge clk);
    start = 1'b0;
    chk("t5_resumed_running", 32'(running), 32'd1);
    wait_to(c + 24);
    halt("t5");

    // Load on a tick edge wins.
    go(8'h01, 1'b1, 3'd1, 1'b0, c);
    push(8'h02, c + 5); push(8'h55, c + 13);
    wait_to(c + 8);
    load = 1'b1; load_pattern = 8'hAA;
    @(negedge clk);
    load = 1'b0;
    chk("t6_load_pattern", 32'(pattern), 32'hAA);
    chk("t6_load_no_step", 32'(step_done), 32'd0);
    wait_to(c + 13);
    halt("t6");
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t6_startstop_running", 32'(running), 32'd0);
    repeat (6) @(negedge clk);
    chk("t6_startstop_pattern", 32'(pattern), 32'h55);

    // Asynchronous reset mid-run.
    go(8'h3C, 1'b1, 3'd2, 1'b0, c);
    wait_to(c + 3);
    chk("t1_pre_running", 32'(running), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_pattern", 32'(pattern), 32'h01);
    chk("t1_async_running", 32'(running), 32'd0);
    chk("t1_async_sh_shifts", 32'(rif.sh_shifts), 32'h0);
    chk("t1_async_sh_a", 32'(rif.sh_a), 32'h01);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
